ram8_16: RTL and testbench
==========================

// Module: ram8_16
//
// PURPOSE
//   Eight-word x 16-bit register bank, the storage stage fed by the 1-to-8
//   demux (write-enable routing) and read through the 8-to-1 mux (word select).
//   Each word has a valid bit, so consumers can tell written data from reset
//   contents. Sits between the 16-bit datapath and the RAM64/RAM512 hierarchy.
//
// PARAMETERS
//   WIDTH      16   data word width in bits
//   RESET_VAL  0    value loaded into every word on reset or clear (WIDTH bits)
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in         in   WIDTH  write data
//   load       in   1      write enable; sampled on rising clk
//   address    in   3      word select; address[0]=sel0, [1]=sel1, [2]=sel2
//   clr        in   1      synchronous clear of all words and valid bits
//   out        out  WIDTH  read data, word[address]
//   out_valid  out  1      valid bit of word[address]
//   full       out  1      high when all 8 valid bits are set
//
// BEHAVIOUR
//   - Reset (rst_n=0, async, any time): all words <= RESET_VAL, all valid <= 0.
//     Outputs read RESET_VAL, out_valid=0, full=0. Effect is immediate and
//     does not wait for clk. A write in flight when rst_n asserts is lost.
//   - Write: on posedge clk with load=1, clr=0:
//     word[address] <= in; valid[address] <= 1. Other words are unchanged.
//   - Read: out, out_valid and full are combinational from the stored state
//     and address. Zero latency on an address change.
//   - Read-during-write: in the cycle load=1, out shows the OLD word. The new
//     value appears after the edge (1-cycle write-to-read latency).
//   - Clear: on posedge clk with clr=1: all words <= RESET_VAL, all valid <= 0.
//     clr has priority over load. A simultaneous write is dropped.
//   - Overwrite: a write to an already-valid word replaces its data. valid
//     stays 1.
//   - full = &valid. It deasserts only on clr or reset; there is no
//     per-word invalidate.
//   - address containing X/Z: out and out_valid are X. This is not a design
//     case; the bench must not drive it.
//   - No internal FSM beyond the storage. The state is words[7:0] + valid[7:0].
//
// CONFIGURATION
//   WRITE_BYPASS_EN
//     defined:   write-through. When load=1 and clr=0, out = in and
//                out_valid = 1 in the same cycle (address is the write
//                address). full is unaffected until the edge.
//     undefined: read-during-write returns the old word and old valid,
//                as described above.
//
// TESTING
//   1. Reset: rst_n=0 mid-cycle after writes -> immediately out=16'h0000,
//      out_valid=0, full=0 at every address.
//   2. Write/read: load=1, address=3, in=16'hBEEF, one edge, then load=0 ->
//      address=3 gives out=16'hBEEF, out_valid=1; addresses 0-2 and 4-7 give
//      out=0, out_valid=0.
//   3. Read-during-write: word5=16'h1234, then load=1, address=5, in=16'hABCD
//      -> before the edge out=16'h1234 (bypass off) or 16'hABCD (bypass on);
//      after the edge out=16'hABCD.
//   4. Fill: write 16'h0101*k at address k for k=0..7 -> full rises after the
//      8th edge, not before; read back all 8 words correctly.
//   5. Clear vs load: with all words valid, clr=1 and load=1, address=2,
//      in=16'hFFFF for one edge -> all out=0, out_valid=0, full=0; word2 is
//      not written.
//   6. Async reset mid-write: load=1, address=7, in=16'h5555; drop rst_n
//      before the edge and release it after -> word7=0, out_valid=0.

Source files
------------

// File: rtl/ram8_16.sv
// Eight-word register bank with a per-word valid bit, combinational read, and synchronous clear.
// Optional `WRITE_BYPASS_EN: write data is forwarded to the read port in the write cycle.
module ram8_16 #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             full
);

  logic [7:0][WIDTH-1:0] words_q, words_d;
  logic [7:0]            valid_q, valid_d;

  // clr outranks load, so a write in the same cycle as a clear is dropped
  always_comb begin
    words_d = words_q;
    valid_d = valid_q;
    if (clr) begin
      words_d = {8{RESET_VAL}};
      valid_d = '0;
    end else if (load) begin
      words_d[address] = in;
      valid_d[address] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= {8{RESET_VAL}};
      valid_q <= '0;
    end else begin
      words_q <= words_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
`ifdef WRITE_BYPASS_EN
    if (load && !clr) begin
      out       = in;
      out_valid = 1'b1;
    end else begin
      out       = words_q[address];
      out_valid = valid_q[address];
    end
`else
    out       = words_q[address];
    out_valid = valid_q[address];
`endif
  end

  assign full = &valid_q;

endmodule

// File: tb/tb_ram8_16.sv
// Directed bench for ram8_16: reset, write/read, read-during-write, fill, clear priority, async reset.
// Expected read-during-write value follows `WRITE_BYPASS_EN.
module tb_ram8_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clr;
  logic [15:0] out;
  logic        out_valid;
  logic        full;

  int n_chk  = 0;
  int n_pass = 0;

  ram8_16 #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .address   (address),
    .clr       (clr),
    .out       (out),
    .out_valid (out_valid),
    .full      (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Inputs change on negedge; the posedge lands mid-pulse.
  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a,
                          input logic [15:0] exp_d, input logic exp_v);
    address = a;
    #1;
    check($sformatf("%s_out%0d", tag, a), {16'h0, out}, {16'h0, exp_d});
    check($sformatf("%s_vld%0d", tag, a), {31'h0, out_valid}, {31'h0, exp_v});
  endtask

  task automatic clear_all();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    in      = '0;
    load    = 1'b0;
    address = '0;
    clr     = 1'b0;
    #12;
    check("rst_full", {31'h0, full}, 32'h0);
    for (int i = 0; i < 8; i++) read_chk("rst", 3'(i), 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then read every address
    write_word(3'd3, 16'hBEEF);
    for (int i = 0; i < 8; i++)
      read_chk("wr", 3'(i), (i == 3) ? 16'hBEEF : 16'h0000, i == 3);

    // Read during write
    write_word(3'd5, 16'h1234);
    @(negedge clk);
    address = 3'd5;
    in      = 16'hABCD;
    load    = 1'b1;
    #1;
`ifdef WRITE_BYPASS_EN
    check("rdw_before", {16'h0, out}, {16'h0, 16'hABCD});
`else
    check("rdw_before", {16'h0, out}, {16'h0, 16'h1234});
`endif
    check("rdw_before_vld", {31'h0, out_valid}, 32'h1);
    @(negedge clk);
    load = 1'b0;
    read_chk("rdw_after", 3'd5, 16'hABCD, 1'b1);
    read_chk("rdw_keep", 3'd3, 16'hBEEF, 1'b1);

    // Async reset mid-cycle after writes
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_full", {31'h0, full}, 32'h0);
    for (int i = 0; i < 8; i++) read_chk("arst", 3'(i), 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill all eight words; full rises only after the eighth edge
    for (int k = 0; k < 8; k++) begin
      write_word(3'(k), 16'h0101 * 16'(k));
      #1;
      check($sformatf("fill_full%0d", k), {31'h0, full}, {31'h0, k == 7});
    end
    for (int k = 0; k < 8; k++) read_chk("fill", 3'(k), 16'h0101 * 16'(k), 1'b1);

    // Overwrite keeps valid and full
    write_word(3'd1, 16'h7E57);
    read_chk("ovw", 3'd1, 16'h7E57, 1'b1);
    check("ovw_full", {31'h0, full}, 32'h1);

    // Clear wins over a simultaneous load
    @(negedge clk);
    clr     = 1'b1;
    load    = 1'b1;
    address = 3'd2;
    in      = 16'hFFFF;
    @(negedge clk);
    clr  = 1'b0;
    load = 1'b0;
    #1;
    check("clr_full", {31'h0, full}, 32'h0);
    for (int i = 0; i < 8; i++) read_chk("clr", 3'(i), 16'h0000, 1'b0);

    // Async reset asserted before a pending write's edge and released after it
    write_word(3'd7, 16'h1111);
    write_word(3'd0, 16'h2222);
    read_chk("pre7", 3'd7, 16'h1111, 1'b1);
    @(negedge clk);
    address = 3'd7;
    in      = 16'h5555;
    load    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_during", {16'h0, out}, {16'h0,
`ifdef WRITE_BYPASS_EN
      16'h5555
`else
      16'h0000
`endif
    });
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    load = 1'b0;
    read_chk("rstw", 3'd7, 16'h0000, 1'b0);
    read_chk("rstw", 3'd0, 16'h0000, 1'b0);

    clear_all();
    read_chk("end", 3'd4, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
